// File: rtl/ldpc_pkg.sv
// Shared LLR types and helpers for the serial min-sum check-node unit.
// Helpers work on a 32-bit container so any WIDTH up to 31 bits can use them.
package ldpc_pkg;

   localparam int LLR_W = 8;

   typedef logic signed [LLR_W-1:0] llr_t;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } cnu_state_e;

   // Saturating magnitude: the most negative code maps to 2^(w-1)-1.
   function automatic logic [31:0] llr_abs_sat(input logic signed [31:0] x, input int unsigned w);
      logic [31:0] maxmag;
      logic [31:0] mag;
      maxmag = (32'd1 << (w - 1)) - 32'd1;
      mag    = x[31] ? 32'(-x) : 32'(x);
      return (mag > maxmag) ? maxmag : mag;
   endfunction

   function automatic logic [31:0] llr_apply_sign(input logic [31:0] mag, input logic neg);
      return (neg && (mag != 32'd0)) ? (32'd0 - mag) : mag;
   endfunction

endpackage

// File: rtl/ldpc_min2_tracker.sv
// Running first/second minimum, index of the first minimum and sign parity
// over a stream of magnitudes; cleared between rows.
module ldpc_min2_tracker
   import ldpc_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MAX_DEG = 8
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_clear,
   input  logic                       i_update,
   input  logic [WIDTH-2:0]           i_mag,
   input  logic                       i_sign,
   input  logic [$clog2(MAX_DEG)-1:0] i_idx,
   output logic [WIDTH-2:0]           o_min1,
   output logic [WIDTH-2:0]           o_min2,
   output logic [$clog2(MAX_DEG)-1:0] o_idx,
   output logic                       o_parity
);

   localparam logic [WIDTH-2:0] MAXMAG = '1;

   logic [WIDTH-2:0]           r_min1;
   logic [WIDTH-2:0]           r_min2;
   logic [$clog2(MAX_DEG)-1:0] r_idx;
   logic                       r_parity;

   // Strict compares keep the earliest index on ties; an equal later value lands in min2.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_min1   <= MAXMAG;
         r_min2   <= MAXMAG;
         r_idx    <= '0;
         r_parity <= 1'b0;
      end else if (i_update) begin
         r_parity <= r_parity ^ i_sign;
         if (i_mag < r_min1) begin
            r_min2 <= r_min1;
            r_min1 <= i_mag;
            r_idx  <= i_idx;
         end else if (i_mag < r_min2) begin
            r_min2 <= i_mag;
         end
      end
   end

   assign o_min1   = r_min1;
   assign o_min2   = r_min2;
   assign o_idx    = r_idx;
   assign o_parity = r_parity;

endmodule

// File: rtl/ldpc_minsigner_serial.sv
// Streaming min-sum check-node unit: accumulates one row, then emits one extrinsic
// message per input position. Define LDPC_MINSIGNER_OFFSET_MIN_SUM_EN for offset min-sum.
module ldpc_minsigner_serial
   import ldpc_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MAX_DEG = 8,
   parameter int OFFSET  = 1
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic signed [WIDTH-1:0]          i_data,
   input  logic                             i_valid,
   input  logic                             i_last,
   output logic                             o_ready,
   output logic signed [WIDTH-1:0]          o_data,
   output logic                             o_valid,
   output logic                             o_last,
   input  logic                             i_ready,
   output logic [$clog2(MAX_DEG+1)-1:0]     o_degree
);

   localparam int CW = $clog2(MAX_DEG + 1);
   localparam int IW = $clog2(MAX_DEG);
   localparam int MW = WIDTH - 1;
   localparam logic [0:0] ST_ACCUM = 1'(ACCUM);
   localparam logic [0:0] ST_EMIT  = 1'(EMIT);

   logic [0:0]         r_state;
   logic [CW-1:0]      r_count;
   logic [CW-1:0]      r_degree;
   logic [IW-1:0]      r_emit_pos;
   logic [MAX_DEG-1:0] r_signs;

   logic               w_accept;
   logic               w_xfer;
   logic               w_row_end;
   logic               w_emit_last;
   logic [MW-1:0]      w_in_mag;
   logic [MW-1:0]      w_min1;
   logic [MW-1:0]      w_min2;
   logic [IW-1:0]      w_idx;
   logic               w_parity;
   logic [MW-1:0]      w_sel_mag;
   logic [MW-1:0]      w_out_mag;
   logic signed [WIDTH-1:0] w_emit_data;

   // Valid/ready: a beat moves on any rising edge where valid && ready; ready never
   // depends on valid, and o_data/o_last/o_degree are register-derived so they hold under stall.
   assign o_ready   = (r_state == ST_ACCUM);
   assign o_valid   = (r_state == ST_EMIT);
   assign w_accept  = i_valid && o_ready;
   assign w_xfer    = o_valid && i_ready;
   assign w_in_mag  = MW'(llr_abs_sat(32'(i_data), WIDTH));
   assign w_row_end = w_accept && (i_last || (r_count == CW'(MAX_DEG - 1)));

   ldpc_min2_tracker #(
      .WIDTH   (WIDTH),
      .MAX_DEG (MAX_DEG)
   ) u_tracker (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_xfer && w_emit_last),
      .i_update (w_accept),
      .i_mag    (w_in_mag),
      .i_sign   (i_data[WIDTH-1]),
      .i_idx    (r_count[IW-1:0]),
      .o_min1   (w_min1),
      .o_min2   (w_min2),
      .o_idx    (w_idx),
      .o_parity (w_parity)
   );

   assign w_emit_last = (CW'(r_emit_pos) == (r_degree - CW'(1)));
   assign w_sel_mag   = (r_emit_pos == w_idx) ? w_min2 : w_min1;

`ifdef LDPC_MINSIGNER_OFFSET_MIN_SUM_EN
   assign w_out_mag = (w_sel_mag > MW'(OFFSET)) ? (w_sel_mag - MW'(OFFSET)) : '0;
`else
   assign w_out_mag = w_sel_mag;
`endif

   assign w_emit_data = WIDTH'(llr_apply_sign(32'(w_out_mag), w_parity ^ r_signs[r_emit_pos]));

   assign o_data   = o_valid ? w_emit_data : '0;
   assign o_last   = o_valid && w_emit_last;
   assign o_degree = o_valid ? r_degree : '0;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= ST_ACCUM;
         r_count    <= '0;
         r_degree   <= '0;
         r_emit_pos <= '0;
         r_signs    <= '0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  r_signs[r_count[IW-1:0]] <= i_data[WIDTH-1];
                  r_count                  <= r_count + CW'(1);
                  if (w_row_end) begin
                     r_state    <= ST_EMIT;
                     r_degree   <= r_count + CW'(1);
                     r_emit_pos <= '0;
                  end
               end
            end
            default: begin
               if (w_xfer) begin
                  if (w_emit_last) begin
                     r_state    <= ST_ACCUM;
                     r_count    <= '0;
                     r_signs    <= '0;
                     r_emit_pos <= '0;
                  end else begin
                     r_emit_pos <= r_emit_pos + IW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_minsigner_serial.sv
// Bench for ldpc_minsigner_serial: rows are driven, expected outputs come from a
// leave-one-out reference model pushed to a scoreboard queue.
module tb_ldpc_minsigner_serial;

   localparam int W       = 8;
   localparam int MAX_DEG = 8;
   localparam int DW      = $clog2(MAX_DEG + 1);
   localparam int OFFSET  = 1;
   localparam int MAXMAG  = (1 << (W - 1)) - 1;

   logic                clk;
   logic                rst;
   logic signed [W-1:0] i_data;
   logic                i_valid;
   logic                i_last;
   logic                o_ready;
   logic signed [W-1:0] o_data;
   logic                o_valid;
   logic                o_last;
   logic                i_ready;
   logic [DW-1:0]       o_degree;

   logic [W-1:0]  exp_q[$];
   logic          exp_last_q[$];
   logic [DW-1:0] exp_deg_q[$];

   int row_buf[16];
   int n_checks;
   int n_fail;

   ldpc_minsigner_serial #(
      .WIDTH   (W),
      .MAX_DEG (MAX_DEG),
      .OFFSET  (OFFSET)
   ) dut (
      .i_clock  (clk),
      .i_reset  (rst),
      .i_data   (i_data),
      .i_valid  (i_valid),
      .i_last   (i_last),
      .o_ready  (o_ready),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .o_last   (o_last),
      .i_ready  (i_ready),
      .o_degree (o_degree)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each output is the min over the other positions, signed by their XOR.
   task automatic push_expected(input int n);
      for (int j = 0; j < n; j++) begin
         int m;
         int s;
         int v;
         m = MAXMAG;
         s = 0;
         for (int k = 0; k < n; k++) begin
            if (k != j) begin
               int a;
               a = (row_buf[k] < 0) ? -row_buf[k] : row_buf[k];
               if (a > MAXMAG) a = MAXMAG;
               if (a < m) m = a;
               if (row_buf[k] < 0) s = s ^ 1;
            end
         end
`ifdef LDPC_MINSIGNER_OFFSET_MIN_SUM_EN
         m = (m > OFFSET) ? m - OFFSET : 0;
`endif
         v = (s != 0) ? -m : m;
         exp_q.push_back(W'(v));
         exp_last_q.push_back(j == n - 1);
         exp_deg_q.push_back(DW'(n));
      end
   endtask

   // driver: one beat per cycle, i_last on the final beat when use_last is set
   task automatic send_row(input int n, input bit use_last, input bit model);
      if (model) push_expected(n);
      for (int i = 0; i < n; i++) begin
         int guard;
         @(negedge clk);
         i_valid = 1'b1;
         i_data  = W'(row_buf[i]);
         i_last  = use_last && (i == n - 1);
         guard   = 0;
         while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (!o_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready: o_ready=%0b required 1 at beat %0d", o_ready, i);
         end
         @(posedge clk);
      end
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_data  = '0;
   endtask

   // Pops `take` outputs; optionally stalls i_ready for stall_cyc cycles on beat stall_beat.
   task automatic collect(input string name, input int take, input int stall_beat, input int stall_cyc);
      for (int j = 0; j < take; j++) begin
         int cnt;
         logic [W-1:0]  e_d;
         logic          e_l;
         logic [DW-1:0] e_g;
         cnt = 0;
         while (!o_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
         n_checks++;
         if (!o_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: o_valid=%0b required 1 at beat %0d", name, o_valid, j);
            return;
         end
         if (j == 0) begin
            n_checks++;
            if (cnt !== 0) begin
               n_fail++;
               $display("FAIL %s_latency: waited %0d cycles required 0", name, cnt);
            end
         end
         n_checks++;
         if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_emit: o_ready=%0b required 0", name, o_ready);
         end
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_extra: unexpected output %0d", name, o_data);
            return;
         end
         e_d = exp_q.pop_front();
         e_l = exp_last_q.pop_front();
         e_g = exp_deg_q.pop_front();
         if (j == stall_beat) begin
            i_ready = 1'b0;
            for (int c = 0; c < stall_cyc; c++) begin
               @(posedge clk);
               @(negedge clk);
               n_checks++;
               if (o_valid !== 1'b1 || o_data !== e_d || o_last !== e_l) begin
                  n_fail++;
                  $display("FAIL %s_stall: valid=%0b data=%0d last=%0b required 1/%0d/%0b",
                           name, o_valid, o_data, o_last, $signed(e_d), e_l);
               end
            end
            i_ready = 1'b1;
         end
         n_checks++;
         if (o_data !== e_d || o_last !== e_l || o_degree !== e_g) begin
            n_fail++;
            $display("FAIL %s_beat%0d: data=%0d last=%0b deg=%0d required %0d/%0b/%0d",
                     name, j, o_data, o_last, o_degree, $signed(e_d), e_l, e_g);
         end
         @(posedge clk);
         @(negedge clk);
      end
      if (exp_q.size() == 0) begin
         n_checks++;
         if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_row_done: ready=%0b valid=%0b required 1/0", name, o_ready, o_valid);
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_idle(input string name);
      n_checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0 || o_degree !== '0) begin
         n_fail++;
         $display("FAIL %s: ready=%0b valid=%0b last=%0b data=%0d deg=%0d required 1/0/0/0/0",
                  name, o_ready, o_valid, o_last, o_data, o_degree);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle("reset_state");
   endtask

   task automatic test_basic_row();
      row_buf[0] = 5; row_buf[1] = -3; row_buf[2] = 7;
      row_buf[3] = 2; row_buf[4] = -9; row_buf[5] = 4;
      send_row(6, 1'b1, 1'b1);
      collect("basic", 6, -1, 0);
   endtask

   task automatic test_saturation();
      row_buf[0] = -128; row_buf[1] = 10;
      send_row(2, 1'b1, 1'b1);
      collect("saturation", 2, -1, 0);
   endtask

   task automatic test_tie();
      row_buf[0] = 4; row_buf[1] = -4; row_buf[2] = 6;
      send_row(3, 1'b1, 1'b1);
      collect("tie", 3, -1, 0);
   endtask

   task automatic test_stall();
      row_buf[0] = 1; row_buf[1] = 2; row_buf[2] = 3;
      send_row(3, 1'b1, 1'b1);
      collect("stall", 3, 1, 3);
   endtask

   task automatic test_max_degree();
      for (int i = 0; i < MAX_DEG; i++) row_buf[i] = 3;
      send_row(MAX_DEG, 1'b0, 1'b1);
      collect("max_deg", MAX_DEG, -1, 0);
   endtask

   task automatic test_reset_mid_emit();
      row_buf[0] = 6; row_buf[1] = -1; row_buf[2] = 8;
      row_buf[3] = 3; row_buf[4] = -2; row_buf[5] = 5;
      send_row(6, 1'b1, 1'b1);
      collect("mid_emit", 2, -1, 0);
      pulse_reset();
      exp_q.delete();
      exp_last_q.delete();
      exp_deg_q.delete();
      check_idle("reset_mid_emit");
      row_buf[0] = -5;
      send_row(1, 1'b1, 1'b1);
      collect("degree1", 1, -1, 0);
   endtask

   task automatic test_reset_mid_accum();
      row_buf[0] = 1; row_buf[1] = 1; row_buf[2] = 1;
      send_row(3, 1'b0, 1'b0);
      pulse_reset();
      check_idle("reset_mid_accum");
      row_buf[0] = 20; row_buf[1] = -30; row_buf[2] = 40;
      send_row(3, 1'b1, 1'b1);
      collect("after_accum_reset", 3, -1, 0);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(MAX_DEG, 1);
         for (int i = 0; i < n; i++) row_buf[i] = $urandom_range(255, 0) - 128;
         send_row(n, 1'b1, 1'b1);
         collect("random", n, (r % 2 == 0) ? $urandom_range(n - 1, 0) : -1, 2);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      i_data   = '0;
      i_valid  = 1'b0;
      i_last   = 1'b0;
      i_ready  = 1'b1;
      test_reset();
      test_basic_row();
      test_saturation();
      test_tie();
      test_stall();
      test_max_degree();
      test_reset_mid_emit();
      test_reset_mid_accum();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
